repeat_responder: RTL and testbench
===================================

# repeat_responder

Sequence responder for the consecutive-repetition handshake: it watches request line `a` and, whenever `a` has been high for `A_REPS` consecutive sampled cycles, drives response line `b` high for `B_REPS` consecutive cycles starting `DELAY` cycles later. It is the driving end of the protocol checked by the `a[*A_REPS] |-> ##DELAY b[*B_REPS]` property. It replaces hand-written testbench stimulus for `b` and can sit in front of any block that expects that response.

## Interface
- `A_REPS`, default 2: consecutive high samples of `a` that form a trigger (1..15).
- `DELAY`, default 2: cycles from the trigger edge to the first required `b` sample (1..15).
- `B_REPS`, default 2: consecutive cycles `b` is held high per trigger (1..15).
- `clk`  in  1: clock; everything samples on posedge.
- `rst_n`  in  1: synchronous active-low reset, sampled on posedge `clk`.
- `a`  in  1: request line.
- `b`  out  1: response line, registered.
- `match`  out  1: registered one-cycle pulse per trigger.
- `busy`  out  1: a response is pending or in progress.
- `trig_cnt`  out  8: saturating count of triggers since reset.

## Operation
- Run counter `run` counts consecutive posedges with `a`=1. It saturates at `A_REPS`-1 and clears on any `a`=0 sample.
- Trigger at edge t: `a`=1 at t and `run` ≥ `A_REPS`-1 (prior highs). With `A_REPS`=1, trigger = `a`.
- Triggers overlap: if `a` stays high past `A_REPS` cycles, every further high edge is a new trigger.
- Each trigger is carried through a `DELAY`-1 stage shift pipeline. When it reaches the end, the hold counter `hold` loads `B_REPS`.
- `b` = (`hold` ≠ 0), registered, so `b` is 1 at the sampling edges t+DELAY … t+DELAY+B_REPS-1.
- A reload while `hold` ≠ 0 restarts the count at `B_REPS`, extending the window. There are no gaps between overlapping windows.
- `hold` decrements once per cycle to 0. It never underflows.
- `match` is 1 for exactly the cycle following each trigger edge.
- `trig_cnt` increments on each trigger and saturates at 255.
- `busy` = any pipeline bit set OR `hold` ≠ 0.
- Reset values: `b`=0, `match`=0, `busy`=0, `trig_cnt`=0, `run`=0, pipeline=0, `hold`=0.
- Reset mid-operation cancels all pending and active responses. `a` samples taken while `rst_n`=0 never count toward a run.
- A run started during reset begins counting at the first edge with `rst_n`=1.
- Hold counter width: $clog2(B_REPS+1). Run counter width: $clog2(A_REPS).

## Timing
- Trigger at edge t: `match` is visible after edge t and sampled 1 at edge t+1.
- `b` register is set at edge t+DELAY-1 and sampled 1 at edges t+DELAY through t+DELAY+B_REPS-1.
- `b` is sampled 0 at t+DELAY+B_REPS unless a later trigger extends the window.
- `DELAY`=1: no pipeline; `hold` loads directly at edge t.
- Simultaneous pipeline arrival and `hold` = 1: the reload wins, so `hold` = `B_REPS` next cycle.
- Latency is fixed. `b` has no input-to-output combinational path.

## Configuration
- `REPEAT_RESPONDER_ASSERT_EN` defined: the block embeds the concurrent assertion `@(posedge clk) disable iff(!rst_n) a[*A_REPS] |-> ##DELAY b[*B_REPS]`. It also embeds a cover on the overlapping-trigger case and parameter-range elaboration checks, with `$error` on failure.
- Undefined: no assertions or covers are compiled. RTL behaviour is identical.

## Structure
- Package `repeat_pkg`:
  - default parameter constants `A_REPS_DEF`, `DELAY_DEF`, `B_REPS_DEF`;
  - `TRIG_CNT_W` = 8;
  - typedef `trig_cnt_t`.
- Sub-module `run_detector`:
  - consecutive-high counter with trigger output;
  - parameter `A_REPS`;
  - ports `clk`, `rst_n`, `a`, `trig`.
- Top module holds the delay pipeline, hold counter, outputs and the optional assertion block.

## Test plan
Defaults; edges numbered from the first posedge after reset release.
- Single trigger: `a`=1 at edges 1,2, else 0 -> `match`=1 at edge 3; `b`=1 at edges 4,5 and 0 at edge 6; `trig_cnt`=1.
- Overlap: `a`=1 at edges 1–3 -> triggers at 2 and 3; `b`=1 at edges 4,5,6 with no gap; `trig_cnt`=2.
- Short pulse: `a`=1 at edge 1 only; separately `a`=1 at edge 1 and edge 3 -> no trigger, `b` stays 0, `busy` stays 0.
- Reset mid-operation: trigger at edge 2, `rst_n`=0 at edge 3 -> `b` never rises; all outputs 0 at edge 4; `trig_cnt`=0.
- Saturation: `a` held 300 cycles -> `trig_cnt` stops at 255; `b` stays continuously 1 from edge 4 until 2 cycles after `a` falls.
- Parameter sweep: `A_REPS`=1, `DELAY`=1, `B_REPS`=3, `a`=1 at edge 5 only -> `b`=1 at edges 6–8; assertion passes with `REPEAT_RESPONDER_ASSERT_EN` defined.

Source files
------------

// File: rtl/repeat_responder_pkg.sv
// Shared defaults and types for the repeat_responder slice.
// Package name repeat_pkg is referenced by run_detector and repeat_responder.
package repeat_pkg;

    localparam int A_REPS_DEF = 2;
    localparam int DELAY_DEF  = 2;
    localparam int B_REPS_DEF = 2;
    localparam int TRIG_CNT_W = 8;

    typedef logic [TRIG_CNT_W-1:0] trig_cnt_t;

    function automatic trig_cnt_t trig_cnt_sat_inc(input trig_cnt_t v);
        return (v == {TRIG_CNT_W{1'b1}}) ? v : v + trig_cnt_t'(1);
    endfunction

endpackage

// File: rtl/repeat_responder_run_detector.sv
// Consecutive-high counter on the request line; trig fires on every edge that
// completes (or extends) a run of A_REPS high samples.
module run_detector
    import repeat_pkg::*;
#(
    parameter int A_REPS = A_REPS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a,
    output logic trig
);

    localparam int RUN_W = (A_REPS > 1) ? $clog2(A_REPS) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(A_REPS - 1);

    logic [RUN_W-1:0] r_run;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_run <= '0;
        end else if (!a) begin
            r_run <= '0;
        end else if (r_run != RUN_MAX) begin
            r_run <= r_run + RUN_W'(1);
        end
    end

    // Saturating at RUN_MAX keeps every further high edge a trigger.
    assign trig = a && (r_run >= RUN_MAX);

endmodule

// File: rtl/repeat_responder.sv
// Drives b high for B_REPS cycles, DELAY cycles after each A_REPS-long run of a.
// Optional macro REPEAT_RESPONDER_ASSERT_EN embeds the protocol assertion and cover.
module repeat_responder
    import repeat_pkg::*;
#(
    parameter int A_REPS = A_REPS_DEF,
    parameter int DELAY  = DELAY_DEF,
    parameter int B_REPS = B_REPS_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      a,
    output logic      b,
    output logic      match,
    output logic      busy,
    output trig_cnt_t trig_cnt
);

    localparam int HOLD_W = $clog2(B_REPS + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(B_REPS);

    logic              w_trig;
    logic              w_arrive;
    logic              w_pipe_busy;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic              r_b;
    logic              r_match;
    trig_cnt_t         r_trig_cnt;

    run_detector #(.A_REPS(A_REPS)) u_run (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .trig  (w_trig)
    );

    generate
        if (DELAY > 1) begin : g_pipe
            logic [DELAY-2:0] r_pipe;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= (r_pipe << 1) | (DELAY-1)'(w_trig);
                end
            end

            assign w_arrive    = r_pipe[DELAY-2];
            assign w_pipe_busy = |r_pipe;
        end else begin : g_nopipe
            assign w_arrive    = w_trig;
            assign w_pipe_busy = 1'b0;
        end
    endgenerate

    // Arrival beats the decrement, so overlapping windows merge without a gap.
    always_comb begin
        w_hold_nxt = r_hold;
        if (w_arrive) begin
            w_hold_nxt = HOLD_LOAD;
        end else if (r_hold != '0) begin
            w_hold_nxt = r_hold - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hold     <= '0;
            r_b        <= 1'b0;
            r_match    <= 1'b0;
            r_trig_cnt <= '0;
        end else begin
            r_hold  <= w_hold_nxt;
            r_b     <= (w_hold_nxt != '0);
            r_match <= w_trig;
            if (w_trig) begin
                r_trig_cnt <= trig_cnt_sat_inc(r_trig_cnt);
            end
        end
    end

    assign b        = r_b;
    assign match    = r_match;
    assign busy     = w_pipe_busy | (r_hold != '0);
    assign trig_cnt = r_trig_cnt;

`ifdef REPEAT_RESPONDER_ASSERT_EN
    generate
        if (A_REPS < 1 || A_REPS > 15) begin : g_bad_a_reps
            $error("repeat_responder: A_REPS out of range 1..15");
        end
        if (DELAY < 1 || DELAY > 15) begin : g_bad_delay
            $error("repeat_responder: DELAY out of range 1..15");
        end
        if (B_REPS < 1 || B_REPS > 15) begin : g_bad_b_reps
            $error("repeat_responder: B_REPS out of range 1..15");
        end
    endgenerate

    property p_response;
        @(posedge clk) disable iff (!rst_n) a[*A_REPS] |-> ##DELAY b[*B_REPS];
    endproperty

    a_response: assert property (p_response)
        else $error("repeat_responder: b response window violated");

    c_overlap: cover property (@(posedge clk) disable iff (!rst_n) a[*(A_REPS+1)]);
`endif

endmodule

// File: tb/tb_repeat_responder.sv
// Directed table-driven bench for repeat_responder (default and swept parameters).
module tb_repeat_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a;
    logic       a2;
    logic       b, match, busy;
    logic [7:0] trig_cnt;
    logic       b2, match2, busy2;
    logic [7:0] trig_cnt2;

    always #5 clk = ~clk;

    repeat_responder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .b        (b),
        .match    (match),
        .busy     (busy),
        .trig_cnt (trig_cnt)
    );

    repeat_responder #(.A_REPS(1), .DELAY(1), .B_REPS(3)) dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a2),
        .b        (b2),
        .match    (match2),
        .busy     (busy2),
        .trig_cnt (trig_cnt2)
    );

    typedef struct {
        logic        rst_n;
        logic        a;
        bit          chk;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   applied     = 0;
    int   miscompares = 0;

    function automatic logic [10:0] pack(input logic eb, input logic em,
                                         input logic ebz, input int cnt);
        return {eb, em, ebz, 8'(cnt)};
    endfunction

    function automatic void add(input logic r, input logic av, input logic eb,
                                input logic em, input logic ebz, input int cnt);
        vecs.push_back('{rst_n: r, a: av, chk: 1'b1, exp: pack(eb, em, ebz, cnt)});
    endfunction

    // Two reset edges; the sample after the first is checked as all-zero.
    function automatic void add_rst(input logic av);
        vecs.push_back('{rst_n: 1'b0, a: av, chk: 1'b0, exp: '0});
        vecs.push_back('{rst_n: 1'b0, a: av, chk: 1'b1, exp: '0});
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [10:0] act, input logic [10:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s[%0d]: got b/match/busy/cnt=%b/%b/%b/%0d, expected %b/%b/%b/%0d",
                     nm, idx, act[10], act[9], act[8], act[7:0],
                     exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        a     = 1'b0;
        a2    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int exp_cnt;
        rst_n = 1'b0;
        a     = 1'b0;
        a2    = 1'b0;

        // Single trigger
        add_rst(1'b0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 1, 1, 1);
        add(1, 0, 1, 0, 1, 1);
        add(1, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 1);
        // Overlapping triggers
        add_rst(1'b0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 1, 1);
        add(1, 0, 1, 1, 1, 2);
        add(1, 0, 1, 0, 1, 2);
        add(1, 0, 1, 0, 1, 2);
        add(1, 0, 0, 0, 0, 2);
        // Short pulses
        add_rst(1'b0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        // Reset mid-operation
        add_rst(1'b0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        // a high during reset must not count toward a run
        add_rst(1'b1);
        add(1, 1, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            if (vecs[i].chk) check("table", i, {b, match, busy, trig_cnt}, vecs[i].exp);
            rst_n = vecs[i].rst_n;
            a     = vecs[i].a;
        end

        // Saturation: a held for edges 1..300
        do_reset();
        for (int k = 1; k <= 306; k++) begin
            @(negedge clk);
            if (k < 3) exp_cnt = 0;
            else begin
                exp_cnt = ((k - 1 < 300) ? k - 1 : 300) - 1;
                if (exp_cnt > 255) exp_cnt = 255;
            end
            check("saturate", k, {b, match, busy, trig_cnt},
                  pack(k >= 4 && k <= 303, k >= 3 && k <= 301, k >= 3 && k <= 303, exp_cnt));
            rst_n = 1'b1;
            a     = (k <= 300);
        end
        a = 1'b0;

        // A_REPS=1, DELAY=1, B_REPS=3: single trigger at edge 5
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("sweep_single", k, {b2, match2, busy2, trig_cnt2},
                  pack(k >= 6 && k <= 8, k == 6, k >= 6 && k <= 8, (k >= 6) ? 1 : 0));
            rst_n = 1'b1;
            a2    = (k == 5);
        end

        // Reload coinciding with hold==1: triggers at edges 5 and 8
        do_reset();
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            check("sweep_reload", k, {b2, match2, busy2, trig_cnt2},
                  pack(k >= 6 && k <= 11, k == 6 || k == 9, k >= 6 && k <= 11,
                       (k >= 9) ? 2 : ((k >= 6) ? 1 : 0)));
            rst_n = 1'b1;
            a2    = (k == 5) || (k == 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
